systolic_feeder: RTL and testbench

- Downstream consumer of the 4x4 operand memory.
- Drives the memory's per-column read_enable/read_elem lines in a diagonal (skewed) wavefront. Column c receives element e at feed step e+c.
- Registers the returned 4-lane word and presents it, with per-lane valid, to the 4x4 systolic array's edge inputs.
- Start/busy/done handshake toward the TPU controller; stall input from the array.

---
 rtl/tpu_pkg.sv | 32 +++
 rtl/skew_addr_gen.sv | 34 +++
 rtl/systolic_feeder.sv | 146 ++++++++++++++
 tb/tb_systolic_feeder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: operand geometry, feed length, feeder state encoding
// and lane pack/unpack index helpers used by memory, feeder and array.
package tpu_pkg;

  // Default width of one memory element / array lane.
  localparam int DEF_DATA_WIDTH = 8;
  // Side length of the square operand memory and systolic array.
  localparam int ARRAY_DIM      = 4;
  // Feed steps needed for the skewed wavefront to sweep all columns.
  localparam int FEED_STEPS     = 2 * ARRAY_DIM - 1;
  // Width of the feed step counter.
  localparam int STEP_W         = 3;
  // Width of one element index.
  localparam int ELEM_W         = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    LAST = 2'd2
  } state_e;

  // Lowest bit of lane 'lane' in a packed multi-lane word.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Highest bit of lane 'lane' in a packed multi-lane word.
  function automatic int lane_hi(input int lane, input int width);
    return (lane + 1) * width - 1;
  endfunction

endpackage

// File: rtl/skew_addr_gen.sv
// Skewed read-address generator for the systolic feeder.
// Column c reads element (step - c) while 0 <= step - c <= 3, producing the
// diagonal wavefront the systolic array expects.
// Ports:
//   step        : current feed step (0..6)
//   feed        : high while the feeder is in its FEED state
//   read_enable : bit c enables memory column c
//   read_elem   : [2c+1:2c] is the element index for column c (0 when disabled)
module skew_addr_gen
  import tpu_pkg::*;
(
  input  logic [STEP_W-1:0]           step,
  input  logic                        feed,
  output logic [ARRAY_DIM-1:0]        read_enable,
  output logic [ELEM_W*ARRAY_DIM-1:0] read_elem
);

  // Per-column enable/element decode. The subtraction is done on 4 bits so
  // step < c is caught before the result is truncated to a 2-bit index.
  always_comb begin
    read_enable = '0;
    read_elem   = '0;
    for (int c = 0; c < ARRAY_DIM; c++) begin
      if (feed && ({1'b0, step} >= 4'(c)) && (({1'b0, step} - 4'(c)) <= 4'd3)) begin
        read_enable[c]               = 1'b1;
        read_elem[ELEM_W*c +: ELEM_W] = 2'(step - 3'(c));
      end else begin
        read_enable[c]               = 1'b0;
        read_elem[ELEM_W*c +: ELEM_W] = 2'b00;
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: sequences one skewed 4x4 read of the operand memory
// and presents each returned word, registered, to the array edge inputs.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a feed sequence (accepted only in IDLE)
//   stall           : array not advancing; freezes the feed step
//   mem_read_enable : per-column memory read enables (combinational)
//   mem_read_elem   : per-column element indices, 2 bits each (combinational)
//   mem_data        : asynchronous read data from memory, lane c at [c*W +: W]
//   array_data      : registered lane data to the array
//   array_valid     : registered per-lane valid
//   busy            : high while feeding (FEED and LAST)
//   done            : one-cycle pulse coinciding with the final word
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            stall,
  output logic [ARRAY_DIM-1:0]            mem_read_enable,
  output logic [ELEM_W*ARRAY_DIM-1:0]     mem_read_elem,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] mem_data,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] array_data,
  output logic [ARRAY_DIM-1:0]            array_valid,
  output logic                            busy,
  output logic                            done
);

  state_e                          state_r;
  state_e                          state_next_s;
  logic [STEP_W-1:0]               step_r;
  logic [STEP_W-1:0]               step_next_s;
  logic                            feed_s;
  logic [ARRAY_DIM-1:0]            rd_en_s;
  logic [ELEM_W*ARRAY_DIM-1:0]     rd_elem_s;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] array_data_r;
  logic [ARRAY_DIM-1:0]            array_valid_r;
  logic                            busy_r;
  logic                            done_r;

  assign feed_s = (state_r == FEED);

  skew_addr_gen u_skew_addr_gen (
    .step        (step_r),
    .feed        (feed_s),
    .read_enable (rd_en_s),
    .read_elem   (rd_elem_s)
  );

  assign mem_read_enable = rd_en_s;
  assign mem_read_elem   = rd_elem_s;

  // State and feed-step register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      step_r  <= 3'd0;
    end else begin
      state_r <= state_next_s;
      step_r  <= step_next_s;
    end
  end

  // Next-state and step logic; stall only matters while feeding.
  always_comb begin
    state_next_s = state_r;
    step_next_s  = step_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = FEED;
          step_next_s  = 3'd0;
        end else begin
          state_next_s = IDLE;
          step_next_s  = 3'd0;
        end
      end
      FEED: begin
        if (stall) begin
          state_next_s = FEED;
          step_next_s  = step_r;
        end else if (step_r == 3'(FEED_STEPS - 1)) begin
          state_next_s = LAST;
          step_next_s  = 3'd0;
        end else begin
          state_next_s = FEED;
          step_next_s  = step_r + 3'd1;
        end
      end
      LAST: begin
        state_next_s = IDLE;
        step_next_s  = 3'd0;
      end
      default: begin
        state_next_s = IDLE;
        step_next_s  = 3'd0;
      end
    endcase
  end

  // Output word register. Disabled columns already read back as zero from
  // memory, so the enable mask doubles as the lane-valid mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      array_data_r  <= '0;
      array_valid_r <= 4'b0000;
    end else begin
      case (state_r)
        FEED: begin
          if (!stall) begin
            array_data_r  <= mem_data;
            array_valid_r <= rd_en_s;
          end else begin
            array_data_r  <= array_data_r;
            array_valid_r <= 4'b0000;
          end
        end
        default: begin
          array_data_r  <= '0;
          array_valid_r <= 4'b0000;
        end
      endcase
    end
  end

  // Status register, derived from the upcoming state so busy/done line up
  // with FEED/LAST cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_next_s == LAST);
    end
  end

  assign array_data  = array_data_r;
  assign array_valid = array_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a behavioural memory plus a
// per-sequence reference timeline built from the feed rules, with directed
// checks of the nominal, stalled, re-started and reset-aborted sequences.
module tb_systolic_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic [3:0]  mem_read_enable;
  logic [7:0]  mem_read_elem;
  logic [31:0] mem_data;
  logic [31:0] array_data;
  logic [3:0]  array_valid;
  logic        busy;
  logic        done;

  logic [7:0]  mem [4][4];

  int n_checks;
  int n_fail;
  int ndone_seen;

  logic [3:0]  cap_en    [32];
  logic [7:0]  cap_elem  [32];
  logic [31:0] cap_data  [32];
  logic [3:0]  cap_valid [32];
  logic        cap_done  [32];
  logic        cap_busy  [32];

  systolic_feeder #(.DATA_WIDTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stall           (stall),
    .mem_read_enable (mem_read_enable),
    .mem_read_elem   (mem_read_elem),
    .mem_data        (mem_data),
    .array_data      (array_data),
    .array_valid     (array_valid),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous memory read port; disabled columns return zero.
  always_comb begin
    mem_data = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (mem_read_enable[c]) mem_data[8*c +: 8] = mem[c][mem_read_elem[2*c +: 2]];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected read pattern and returned word for feed step t.
  task automatic exp_word(input int t, output logic [3:0] en, output logic [7:0] el,
                          output logic [31:0] w);
    en = 4'h0; el = 8'h0; w = 32'h0;
    for (int c = 0; c < 4; c++) begin
      int e;
      e = t - c;
      if (e >= 0 && e <= 3) begin
        en[c]        = 1'b1;
        el[2*c +: 2] = 2'(e);
        w[8*c +: 8]  = mem[c][e];
      end
    end
  endtask

  task automatic cmp(input logic [3:0] en, input logic [7:0] el, input logic [31:0] d,
                     input logic [3:0] v, input logic b, input logic dn, input int cyc);
    check_val($sformatf("enable@%0d", cyc), 64'(mem_read_enable), 64'(en));
    check_val($sformatf("elem@%0d", cyc),   64'(mem_read_elem),   64'(el));
    check_val($sformatf("data@%0d", cyc),   64'(array_data),      64'(d));
    check_val($sformatf("valid@%0d", cyc),  64'(array_valid),     64'(v));
    check_val($sformatf("busy@%0d", cyc),   64'(busy),            64'(b));
    check_val($sformatf("done@%0d", cyc),   64'(done),            64'(dn));
    if (cyc < 32) begin
      cap_en[cyc] = mem_read_enable; cap_elem[cyc] = mem_read_elem;
      cap_data[cyc] = array_data; cap_valid[cyc] = array_valid;
      cap_done[cyc] = done; cap_busy[cyc] = busy;
    end
    if (done) ndone_seen++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp(4'h0, 8'h0, 32'h0, 4'h0, 1'b0, 1'b0, 31);
      start = 1'b0;
      stall = 1'($urandom_range(0, 1));
    end
  endtask

  // One feed sequence. Cycle 0 is the IDLE cycle where start is driven.
  // smask bit k stalls the k-th FEED cycle. 'noisy' re-pulses start while busy.
  // 'chained' means cycle 0 was the previous sequence's trailing cycle.
  // abort_step >= 0 pulls rst_n low during the cycle showing that step.
  task automatic run_seq(input logic [15:0] smask, input bit noisy, input bit chained,
                         input bit chain_next, input int abort_step);
    logic [31:0] pdata;
    logic [3:0]  pvalid;
    logic [3:0]  een;
    logic [7:0]  eel;
    logic [31:0] w;
    int t, k, cyc;
    pdata = 32'h0; pvalid = 4'h0; t = 0; k = 0;
    if (!chained) begin
      @(negedge clk);
      cmp(4'h0, 8'h0, 32'h0, 4'h0, 1'b0, 1'b0, 0);
      start = 1'b1;
      stall = 1'($urandom_range(0, 1));
    end
    ndone_seen = 0;
    cyc = 1;
    while (t < 7) begin
      @(negedge clk);
      exp_word(t, een, eel, w);
      cmp(een, eel, pdata, pvalid, 1'b1, 1'b0, cyc);
      if (abort_step == t) begin
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_enable", 64'(mem_read_enable), 64'h0);
        check_val("abort_elem",   64'(mem_read_elem),   64'h0);
        check_val("abort_data",   64'(array_data),      64'h0);
        check_val("abort_valid",  64'(array_valid),     64'h0);
        check_val("abort_busy",   64'(busy),            64'h0);
        check_val("abort_done",   64'(done),            64'h0);
        start = 1'b0; stall = 1'b0;
        @(negedge clk);
        cmp(4'h0, 8'h0, 32'h0, 4'h0, 1'b0, 1'b0, 30);
        rst_n = 1'b1;
        check_val("abort_no_done", 64'(ndone_seen), 64'd0);
        return;
      end
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      stall = (k < 16) ? smask[k] : 1'b0;
      if (stall) begin
        pvalid = 4'h0;
      end else begin
        pdata  = w;
        pvalid = een;
        t++;
      end
      k++; cyc++;
    end
    // LAST: final word, done pulse.
    @(negedge clk);
    cmp(4'h0, 8'h0, pdata, pvalid, 1'b1, 1'b1, cyc);
    start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    stall = 1'($urandom_range(0, 1));
    // Trailing IDLE cycle: everything cleared.
    @(negedge clk);
    cmp(4'h0, 8'h0, 32'h0, 4'h0, 1'b0, 1'b0, cyc + 1);
    check_val("one_done", 64'(ndone_seen), 64'd1);
    start = chain_next;
    stall = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [27:0] nom_en;
    logic        ch;
    n_checks = 0; n_fail = 0; ndone_seen = 0;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int e = 0; e < 4; e++) mem[c][e] = 8'(16 * c + e);

    repeat (2) @(negedge clk);
    cmp(4'h0, 8'h0, 32'h0, 4'h0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Nominal sequence, no stalls.
    run_seq(16'h0000, 1'b0, 1'b0, 1'b0, -1);
    nom_en = {4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
    for (int i = 1; i <= 7; i++)
      check_val($sformatf("nom_enable_%0d", i), 64'(cap_en[i]), 64'(nom_en[4*(i-1) +: 4]));
    check_val("nom_elem_step3",  64'(cap_elem[4]),  64'h1B);
    check_val("nom_data_step3",  64'(cap_data[5]),  64'h30211203);
    check_val("nom_valid_step3", 64'(cap_valid[5]), 64'hF);
    check_val("nom_last_data",   64'(cap_data[8]),  64'h33000000);
    check_val("nom_last_valid",  64'(cap_valid[8]), 64'h8);
    check_val("nom_last_done",   64'(cap_done[8]),  64'h1);
    check_val("nom_last_busy",   64'(cap_busy[8]),  64'h1);
    check_val("nom_after_busy",  64'(cap_busy[9]),  64'h0);

    // Two stall cycles at step 2.
    run_seq(16'h000C, 1'b0, 1'b0, 1'b0, -1);
    check_val("stall_elem_a",  64'(cap_elem[4]),  64'h06);
    check_val("stall_elem_b",  64'(cap_elem[5]),  64'h06);
    check_val("stall_valid_a", 64'(cap_valid[4]), 64'h0);
    check_val("stall_valid_b", 64'(cap_valid[5]), 64'h0);
    check_val("stall_data_a",  64'(cap_data[4]),  64'h00001001);
    check_val("stall_data_b",  64'(cap_data[5]),  64'h00001001);
    check_val("stall_done10",  64'(cap_done[10]), 64'h1);

    // start noise while busy, then a back-to-back sequence.
    run_seq(16'h0000, 1'b1, 1'b0, 1'b1, -1);
    run_seq(16'h0000, 1'b0, 1'b1, 1'b0, -1);

    // Reset abort at step 4, then a clean sequence.
    run_seq(16'h0000, 1'b0, 1'b0, 1'b0, 4);
    run_seq(16'h0000, 1'b0, 1'b0, 1'b0, -1);

    // Randomized sequences with random memory, stalls, noise and chaining.
    ch = 1'b0;
    for (int s = 0; s < 30; s++) begin
      logic nxt;
      for (int c = 0; c < 4; c++)
        for (int e = 0; e < 4; e++) mem[c][e] = 8'($urandom);
      nxt = 1'($urandom_range(0, 1));
      run_seq(16'($urandom & $urandom), 1'($urandom_range(0, 1)), ch, nxt, -1);
      ch = nxt;
      if (!ch) idle_cycles($urandom_range(0, 3));
    end
    if (ch) run_seq(16'h0000, 1'b0, 1'b1, 1'b0, -1);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
